hex_display_pio: RTL

Parametrised Avalon-MM slave that drives up to eight active-low seven-segment hex digits from a memory-mapped register set. It is the successor to the plain 16-bit hex-digit output PIO: it adds a configurable digit count, per-digit enable (blanking), per-digit blinking from an internal prescaler, and registered segment decode. It sits on the system interconnect beside the other PIOs, and its outputs go directly to the board HEX displays.

---
 rtl/hex_display_pkg.sv | 18 +
 rtl/hex7seg_decode.sv | 11 +
 rtl/hex_display_pio.sv | 105 ++++++++++
 3 files changed

// File: rtl/hex_display_pkg.sv
// Shared constants for the hex display PIO: register map, blank pattern and
// the active-low seven-segment glyph table (segment a in bit 0).
package hex_display_pkg;

   localparam logic [1:0] ADDR_DATA   = 2'd0;
   localparam logic [1:0] ADDR_ENABLE = 2'd1;
   localparam logic [1:0] ADDR_BLINK  = 2'd2;
   localparam logic [1:0] ADDR_STATUS = 2'd3;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Entry 15 first so that GLYPHS[v] is the glyph of hex value v.
   localparam logic [15:0][6:0] GLYPHS = {
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

endpackage

// File: rtl/hex7seg_decode.sv
// Combinational 4-bit to active-low seven-segment decoder.
module hex7seg_decode
   import hex_display_pkg::*;
(
   input  logic [3:0] value,
   output logic [6:0] seg
);

   assign seg = GLYPHS[value];

endmodule

// File: rtl/hex_display_pio.sv
// Avalon-MM hex display PIO with per-digit enable and registered segment decode.
// Blinking (BLINK register, prescaler, blink_phase) exists only when HEX_DISPLAY_PIO_BLINK_EN is defined.
module hex_display_pio
   import hex_display_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int BLINK_DIV  = 24
)(
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [1:0]              address,
   input  logic                    chipselect,
   input  logic                    write_n,
   input  logic [31:0]             writedata,
   output logic [31:0]             readdata,
   output logic [7*NUM_DIGITS-1:0] hex_n,
   output logic                    blink_phase
);

   localparam int W = 4 * NUM_DIGITS;

   logic                             wr;
   logic [W-1:0]                     data_reg;
   logic [NUM_DIGITS-1:0]            enable_reg;
   logic [NUM_DIGITS-1:0]            blink_bits;
   logic                             phase;
   logic [NUM_DIGITS-1:0]            blank_p0;
   logic [NUM_DIGITS-1:0][6:0]       glyph_p0;
   logic [NUM_DIGITS-1:0][6:0]       hex_p1;
   logic                             unused_wdata;

   assign wr           = chipselect & ~write_n;
   assign unused_wdata = ^writedata;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_reg   <= '0;
         enable_reg <= '1;
      end else if (wr) begin
         if (address == ADDR_DATA)   data_reg   <= writedata[W-1:0];
         if (address == ADDR_ENABLE) enable_reg <= writedata[NUM_DIGITS-1:0];
      end
   end

`ifdef HEX_DISPLAY_PIO_BLINK_EN
   logic [BLINK_DIV-1:0]  prescale;
   logic [NUM_DIGITS-1:0] blink_reg;

   // The prescaler free-runs; BLINK writes deliberately leave it and the phase alone.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prescale  <= '0;
         phase     <= 1'b0;
         blink_reg <= '0;
      end else begin
         prescale <= prescale + 1'b1;
         if (&prescale) phase <= ~phase;
         if (wr && address == ADDR_BLINK) blink_reg <= writedata[NUM_DIGITS-1:0];
      end
   end

   assign blink_bits = blink_reg;
`else
   assign blink_bits = '0;
   assign phase      = 1'b0;
`endif

   assign blink_phase = phase;

   // Stage p0: decode from the live register values
   assign blank_p0 = ~enable_reg | (blink_bits & {NUM_DIGITS{phase}});

   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
      hex7seg_decode u_dec (
         .value (data_reg[4*i +: 4]),
         .seg   (glyph_p0[i])
      );
   end

   // Stage p1: registered segment outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hex_p1 <= {NUM_DIGITS{GLYPHS[0]}};
      end else begin
         for (int i = 0; i < NUM_DIGITS; i++)
            hex_p1[i] <= blank_p0[i] ? SEG_BLANK : glyph_p0[i];
      end
   end

   assign hex_n = hex_p1;

   always_comb begin
      readdata = '0;
      case (address)
         ADDR_DATA:   readdata[W-1:0]          = data_reg;
         ADDR_ENABLE: readdata[NUM_DIGITS-1:0] = enable_reg;
         ADDR_BLINK:  readdata[NUM_DIGITS-1:0] = blink_bits;
         default: begin
            readdata[0]    = phase;
            readdata[11:8] = 4'(NUM_DIGITS);
         end
      endcase
   end

endmodule
